// File: rtl/ro_sampler.sv
// rtl/ro_sampler.sv - ring-oscillator TRNG sampler: sync, XOR, divided strobe, von Neumann debias, pack, RCT health test
module ro_sampler #(
  parameter int N    = 8,
  parameter int W    = 32,
  parameter int DIV  = 4,
  parameter int WARM = 16,
  parameter int RCT  = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  input  logic [N-1:0] RO_IN,
  output logic         RO_RESET,
  output logic [W-1:0] DATA_O,
  output logic         VALID_O,
  input  logic         READY_I,
  output logic         FAIL_O
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int KW = $clog2(WARM);
  localparam int BW = $clog2(W);
  localparam int RW = $clog2(RCT + 1);

  typedef enum logic [2:0] {IDLE, WARM_UP, COLLECT, HOLD, FAILED} state_t;

  state_t          state;
  logic [N-1:0]    sync1, sync2;
  logic [DW-1:0]   div_cnt;
  logic [KW-1:0]   warm_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [RW-1:0]   run_cnt;
  logic [W-1:0]    sr;
  logic            pair, stored, last_raw;

  logic            raw, active, strobe, rct_hit, out_free;
  logic [RW-1:0]   run_next;
  logic [W-1:0]    word;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= RO_IN;
      sync2 <= sync1;
    end
  end

  assign raw      = ^sync2;
  assign active   = (state == WARM_UP) || (state == COLLECT);
  assign strobe   = active && (div_cnt == DW'(DIV - 1));
  assign run_next = ((run_cnt == '0) || (raw != last_raw)) ? RW'(1) : run_cnt + RW'(1);
  assign rct_hit  = strobe && (run_next == RW'(RCT));
  assign out_free = !VALID_O || READY_I;
  assign word     = {sr[W-2:0], stored};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      RO_RESET <= 1'b1;
      DATA_O   <= '0;
      VALID_O  <= 1'b0;
      FAIL_O   <= 1'b0;
      div_cnt  <= '0;
      warm_cnt <= '0;
      bit_cnt  <= '0;
      run_cnt  <= '0;
      sr       <= '0;
      pair     <= 1'b0;
      stored   <= 1'b0;
      last_raw <= 1'b0;
    end else begin
      RO_RESET <= (state == IDLE) || (state == FAILED);
      if (VALID_O && READY_I) VALID_O <= 1'b0;

      unique case (state)
        IDLE: if (EN && !FAIL_O) state <= WARM_UP;

        WARM_UP, COLLECT, HOLD: begin
          if (rct_hit || !EN) begin
            div_cnt  <= '0;
            warm_cnt <= '0;
            bit_cnt  <= '0;
            run_cnt  <= '0;
            sr       <= '0;
            pair     <= 1'b0;
            stored   <= 1'b0;
            last_raw <= 1'b0;
            // A health failure outranks both the word load and EN=0.
            if (rct_hit) begin
              state   <= FAILED;
              FAIL_O  <= 1'b1;
              VALID_O <= 1'b0;
              DATA_O  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (state != HOLD) div_cnt <= strobe ? '0 : div_cnt + DW'(1);
            if (strobe) begin
              run_cnt  <= run_next;
              last_raw <= raw;
            end
            if (state == WARM_UP && strobe) begin
              if (warm_cnt == KW'(WARM - 1)) begin
                warm_cnt <= '0;
                state    <= COLLECT;
              end else begin
                warm_cnt <= warm_cnt + KW'(1);
              end
            end
            if (state == COLLECT && strobe) begin
              if (!pair) begin
                stored <= raw;
                pair   <= 1'b1;
              end else begin
                pair <= 1'b0;
                if (raw != stored) begin
                  if (bit_cnt == BW'(W - 1)) begin
                    bit_cnt <= '0;
                    if (out_free) begin
                      DATA_O  <= word;
                      VALID_O <= 1'b1;
                    end else begin
                      // Park the finished word in sr until the output frees.
                      sr    <= word;
                      state <= HOLD;
                    end
                  end else begin
                    sr      <= word;
                    bit_cnt <= bit_cnt + BW'(1);
                  end
                end
              end
            end
            if (state == HOLD && out_free) begin
              DATA_O  <= sr;
              VALID_O <= 1'b1;
              state   <= COLLECT;
            end
          end
        end

        FAILED: state <= FAILED;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_sampler.sv
// tb/tb_ro_sampler.sv - directed self-checking bench for ro_sampler
module tb_ro_sampler;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_a, ready_a, ro_reset_a, valid_a, fail_a;
  logic [1:0]  ro_a;
  logic [31:0] data_a;
  logic        en_b, ready_b, ro_reset_b, valid_b, fail_b;
  logic [1:0]  ro_b;
  logic [31:0] data_b;

  int total = 0;
  int bad   = 0;
  int rel   = 0;
  bit pat_on = 1'b0;
  int ph    = 0;
  logic [3:0] pat = 4'b0110;

  always #5 clk = ~clk;

  ro_sampler #(.N(2), .W(32), .DIV(1), .WARM(16), .RCT(32)) u_a (
    .CLK(clk), .RESET(reset), .EN(en_a), .RO_IN(ro_a), .RO_RESET(ro_reset_a),
    .DATA_O(data_a), .VALID_O(valid_a), .READY_I(ready_a), .FAIL_O(fail_a)
  );

  ro_sampler #(.N(2), .W(32), .DIV(2), .WARM(16), .RCT(32)) u_b (
    .CLK(clk), .RESET(reset), .EN(en_b), .RO_IN(ro_b), .RO_RESET(ro_reset_b),
    .DATA_O(data_b), .VALID_O(valid_b), .READY_I(ready_b), .FAIL_O(fail_b)
  );

  // Oscillator 0 follows 0,1,1,0 from phase ph; oscillator 1 is held low.
  always @(negedge clk) begin
    if (pat_on) begin
      ro_a = {1'b0, pat[ph]};
      ph   = (ph + 1) % 4;
    end else begin
      ro_a = 2'b00;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    en_a    = 1'b0;
    en_b    = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    ro_b    = 2'b00;
    step();
    reset = 1'b0;
  endtask

  // Phase 1 makes the first COLLECT strobe sample a 0 at the start of a 0,1 pair.
  task automatic start_a();
    en_a   = 1'b1;
    ph     = 1;
    pat_on = 1'b1;
    rel    = -1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if ({ro_reset_a, valid_a, fail_a} !== 3'b100 || data_a !== 32'h0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: got ro_reset=%b valid=%b fail=%b data=%h want 1 0 0 00000000",
                 i, ro_reset_a, valid_a, fail_a, data_a);
      end
    end
  endtask

  task automatic test_stream();
    int first, second;
    logic v_after;
    logic [31:0] d1, d2;
    first = -1; second = -1; v_after = 1'b1; d1 = '0; d2 = '0;
    do_reset();
    ready_a = 1'b1;
    start_a();
    while (rel < 300) begin
      step();
      if (first >= 0 && rel == first + 1) v_after = valid_a;
      else if (valid_a && first < 0) begin first = rel; d1 = data_a; end
      else if (valid_a && first >= 0 && second < 0) begin second = rel; d2 = data_a; end
    end
    total++;
    if (first < 80 || first > 84) begin
      bad++; $display("FAIL stream_latency: got %0d want 80..84", first);
    end
    total++;
    if (d1 !== 32'h55555555) begin
      bad++; $display("FAIL stream_word1: got %h want 55555555", d1);
    end
    total++;
    if (v_after !== 1'b0) begin
      bad++; $display("FAIL stream_valid_drop: got %b want 0", v_after);
    end
    total++;
    if (second - first != 64) begin
      bad++; $display("FAIL stream_interval: got %0d want 64", second - first);
    end
    total++;
    if (d2 !== 32'h55555555) begin
      bad++; $display("FAIL stream_word2: got %h want 55555555", d2);
    end
  endtask

  task automatic test_en_drop();
    int first;
    logic [31:0] d1;
    first = -1; d1 = '0;
    do_reset();
    ready_a = 1'b1;
    start_a();
    while (rel < 56) step();
    total++;
    if (valid_a !== 1'b0) begin
      bad++; $display("FAIL drop_no_word: got %b want 0", valid_a);
    end
    en_a = 1'b0;
    while (rel < 61) step();
    total++;
    if (ro_reset_a !== 1'b1) begin
      bad++; $display("FAIL drop_ro_reset: got %b want 1", ro_reset_a);
    end
    step();
    step();
    start_a();
    while (rel < 300) begin
      step();
      if (valid_a && first < 0) begin first = rel; d1 = data_a; end
    end
    total++;
    if (first < 80 || first > 84) begin
      bad++; $display("FAIL drop_relatency: got %0d want 80..84", first);
    end
    total++;
    if (d1 !== 32'h55555555) begin
      bad++; $display("FAIL drop_fresh_word: got %h want 55555555", d1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_a();
    while (rel < 100) step();
    total++;
    if (valid_a !== 1'b1 || data_a !== 32'h55555555) begin
      bad++; $display("FAIL hold_word1: got valid=%b data=%h want 1 55555555", valid_a, data_a);
    end
    while (rel < 200) step();
    total++;
    if (valid_a !== 1'b1 || data_a !== 32'h55555555) begin
      bad++; $display("FAIL hold_stable: got valid=%b data=%h want 1 55555555", valid_a, data_a);
    end
    while (rel < 207) step();
    ready_a = 1'b1;
    step();
    total++;
    if (valid_a !== 1'b1 || data_a !== 32'h55555555) begin
      bad++; $display("FAIL b2b_reload: got valid=%b data=%h want 1 55555555", valid_a, data_a);
    end
    step();
    total++;
    if (valid_a !== 1'b0) begin
      bad++; $display("FAIL b2b_drain: got %b want 0", valid_a);
    end
    while (rel < 271) step();
    total++;
    if (valid_a !== 1'b0) begin
      bad++; $display("FAIL hold_no_early: got %b want 0", valid_a);
    end
    step();
    total++;
    if (valid_a !== 1'b1 || data_a !== 32'h55555555) begin
      bad++; $display("FAIL hold_resume_word: got valid=%b data=%h want 1 55555555", valid_a, data_a);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_a();
    while (rel < 100) step();
    total++;
    if (valid_a !== 1'b1) begin
      bad++; $display("FAIL rmid_pre_valid: got %b want 1", valid_a);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    en_a  = 1'b0;
    total++;
    if (valid_a !== 1'b0 || data_a !== 32'h0 || ro_reset_a !== 1'b1) begin
      bad++; $display("FAIL rmid_cleared: got valid=%b data=%h ro_reset=%b want 0 00000000 1",
                      valid_a, data_a, ro_reset_a);
    end
  endtask

  task automatic test_fail();
    do_reset();
    en_b = 1'b1;
    rel  = -1;
    while (rel < 63) step();
    total++;
    if (fail_b !== 1'b0 || ro_reset_b !== 1'b0) begin
      bad++; $display("FAIL rct_pre: got fail=%b ro_reset=%b want 0 0", fail_b, ro_reset_b);
    end
    step();
    total++;
    if (fail_b !== 1'b1) begin
      bad++; $display("FAIL rct_trip: got %b want 1", fail_b);
    end
    while (rel < 66) step();
    total++;
    if (ro_reset_b !== 1'b1 || valid_b !== 1'b0) begin
      bad++; $display("FAIL rct_ro_reset: got ro_reset=%b valid=%b want 1 0", ro_reset_b, valid_b);
    end
    for (int i = 0; i < 20; i++) begin
      en_b = i[0];
      step();
      total++;
      if (fail_b !== 1'b1 || ro_reset_b !== 1'b1) begin
        bad++; $display("FAIL rct_sticky cyc=%0d: got fail=%b ro_reset=%b want 1 1", i, fail_b, ro_reset_b);
      end
    end
    do_reset();
    total++;
    if (fail_b !== 1'b0) begin
      bad++; $display("FAIL rct_clear: got %b want 0", fail_b);
    end
  endtask

  initial begin
    reset = 1'b1; en_a = 1'b0; en_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0; ro_b = 2'b00;
    test_reset();
    test_stream();
    test_en_drop();
    test_back_to_back();
    test_reset_mid();
    test_fail();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
